booth_multiplier: RTL and testbench
===================================

# booth_multiplier

Sequential signed 64×64 Booth multiplier that sits directly downstream of the factorial controller. It receives the controller's registered multiplier and multiplicand operands together with its start and clear strobes. It returns a 128-bit product split into result_h and result_l, plus a done flag. The product is computed iteratively, one Booth step per clock.

## Interface
- No parameters. Operand width is fixed at 64 and product width at 128.
- clk  in  1  Single clock; every register updates on its rising edge.
- reset  in  1  Synchronous, active-high reset, sampled on the rising edge of clk.
- op_start  in  1  Level-sensitive start request. The controller holds it high until op_done.
- op_clear  in  1  Level-sensitive clear/abort. Has priority over op_start.
- multiplier  in  64  Signed two's-complement operand Q.
- multiplicand  in  64  Signed two's-complement operand M.
- result_h  out  64  Product bits [127:64].
- result_l  out  64  Product bits [63:0].
- op_done  out  1  High while a valid product is held.

## Operation
- FSM states: IDLE, EXEC, DONE. Each reset or op_clear edge forces IDLE with:
  - op_done = 0
  - result_h = result_l = 0
  - iteration counter = 0
  - working registers = 0
- IDLE → EXEC on an edge with op_start=1 and op_clear=0. On that edge:
  - M is latched from multiplicand.
  - Q is latched from multiplier.
  - Accumulator A = 0, q₋₁ = 0, counter = 0.
  - result_h/result_l are cleared.
- After that edge, operand inputs are ignored until the next IDLE→EXEC transition. The controller changes its multiplier register while op_start is high.
- Each EXEC step, radix-2 mode:
  - Examine {Q[0], q₋₁}.
  - 01 → A += M. 10 → A −= M. 00 and 11 → no change.
  - Then arithmetic shift right of {A, Q, q₋₁} by 1.
  - A is 65 bits, sign-extended from M.
- EXEC → DONE on the edge that completes the final step. On that edge:
  - result_h = A[63:0] of the shifted value.
  - result_l = Q.
  - op_done = 1.
- DONE holds result_h, result_l and op_done=1 regardless of op_start. It exits only through op_clear or reset.
- result_h/result_l never expose partial products. They are 0 during EXEC.
- op_start=1 and op_clear=1 on the same edge: op_clear wins and the block stays in or enters IDLE.
- op_clear mid-EXEC aborts the operation. There is no residual state and the next start behaves as from reset.
- All arithmetic is modulo 2^128 signed. The full 128-bit signed product is always exact, including −2^63 × −2^63 = 2^126.

## Timing
- Start edge S0 is the first edge with op_start=1 in IDLE.
- Radix-2: 64 EXEC edges. op_done and the result are visible after edge S0+64.
- Radix-4 (see Configuration): 32 EXEC edges. Result is visible after edge S0+32.
- op_clear takes effect on the edge it is sampled, so outputs are 0 from the next cycle.
- Result stays stable in DONE for as long as the block remains there. The controller reads it in its following states, before its registered clear arrives.
- Reset value of every output is 0.

## Configuration
- BOOTH_RADIX4_EN defined: modified radix-4 Booth.
  - Each step examines {Q[1:0], q₋₁}.
  - Encodings: 000/111 → +0; 001/010 → +M; 011 → +2M; 100 → −2M; 101/110 → −M.
  - Then arithmetic shift right by 2.
  - A is 66 bits.
  - 32 steps; counter is 5 bits.
- Undefined: radix-2 as described above.
  - 64 steps; counter is 6 bits.
- Interface, FSM and output behaviour are identical in both modes. Only the latency differs.

## Test plan
- 5 × 4 → result_h=0, result_l=0x14. op_done rises exactly 64 edges after S0 (32 with BOOTH_RADIX4_EN). op_done stays high for 20 cycles of held op_start.
- −3 × 7 → result_h=0xFFFF_FFFF_FFFF_FFFF, result_l=0xFFFF_FFFF_FFFF_FFEB.
- 0x7FFF_FFFF_FFFF_FFFF × 0x7FFF_FFFF_FFFF_FFFF → result_h=0x3FFF_FFFF_FFFF_FFFF, result_l=0x0000_0000_0000_0001. Also −2^63 × −1 → result_h=0, result_l=0x8000_0000_0000_0000, in both modes.
- Start 6 × 5, then drive multiplier=0 and multiplicand=0xFF from S0+1 onward → result_l=30, result_h=0.
- Start 9 × 9, assert op_clear at S0+10 for one cycle → op_done=0 and results 0 from S0+11, state IDLE. Restart with 3 × 3 → result_l=9 at the nominal latency.
- Assert op_start and op_clear together for 5 cycles → stays IDLE with all outputs 0. Assert reset during DONE → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/booth_multiplier_if.sv
// booth_multiplier_if: start/clear strobes, operands and product bus
// between the factorial controller (master) and the Booth multiplier (slave).
interface booth_multiplier_if;
    logic        op_start;
    logic        op_clear;
    logic [63:0] multiplier;
    logic [63:0] multiplicand;
    logic [63:0] result_h;
    logic [63:0] result_l;
    logic        op_done;

    modport master (
        output op_start, op_clear, multiplier, multiplicand,
        input  result_h, result_l, op_done
    );

    modport slave (
        input  op_start, op_clear, multiplier, multiplicand,
        output result_h, result_l, op_done
    );
endinterface

// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential signed 64x64 Booth multiplier, one step per clock.
// Define BOOTH_RADIX4_EN for modified radix-4 Booth (32 steps instead of 64).
module booth_multiplier (
    input  logic              clk,
    input  logic              reset,
    booth_multiplier_if.slave bus
);
`ifdef BOOTH_RADIX4_EN
    localparam int AW = 66;
    localparam int CW = 5;
`else
    localparam int AW = 65;
    localparam int CW = 6;
`endif

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_sum;
    logic [AW-1:0] acc_sh;
    logic [AW-1:0] m_ext;
    logic [63:0]   m;
    logic [63:0]   q;
    logic [63:0]   q_sh;
    logic          q_m1;
    logic          q_m1_sh;
    logic [CW-1:0] cnt;
    logic          last;
    logic [63:0]   res_h;
    logic [63:0]   res_l;
    logic          done;

    assign m_ext = {{(AW-64){m[63]}}, m};
    assign last  = (cnt == {CW{1'b1}});

`ifdef BOOTH_RADIX4_EN
    // Extra accumulator bit keeps +/-2M exact for M = -2^63.
    always_comb begin
        acc_sum = acc;
        case ({q[1:0], q_m1})
            3'b001, 3'b010: acc_sum = acc + m_ext;
            3'b011:         acc_sum = acc + (m_ext << 1);
            3'b100:         acc_sum = acc - (m_ext << 1);
            3'b101, 3'b110: acc_sum = acc - m_ext;
            default:        acc_sum = acc;
        endcase
        acc_sh  = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
        q_sh    = {acc_sum[1:0], q[63:2]};
        q_m1_sh = q[1];
    end
`else
    always_comb begin
        acc_sum = acc;
        case ({q[0], q_m1})
            2'b01:   acc_sum = acc + m_ext;
            2'b10:   acc_sum = acc - m_ext;
            default: acc_sum = acc;
        endcase
        acc_sh  = {acc_sum[AW-1], acc_sum[AW-1:1]};
        q_sh    = {acc_sum[0], q[63:1]};
        q_m1_sh = q[0];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!bus.op_clear && bus.op_start) state_next = EXEC;
            end
            EXEC: begin
                if (bus.op_clear) state_next = IDLE;
                else if (last)    state_next = DONE;
            end
            DONE: begin
                if (bus.op_clear) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Results stay zero until the final step so no partial product leaks out.
    always_ff @(posedge clk) begin
        if (reset || bus.op_clear) begin
            acc   <= '0;
            m     <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
            res_h <= '0;
            res_l <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.op_start) begin
                        m     <= bus.multiplicand;
                        q     <= bus.multiplier;
                        acc   <= '0;
                        q_m1  <= 1'b0;
                        cnt   <= '0;
                        res_h <= '0;
                        res_l <= '0;
                        done  <= 1'b0;
                    end
                end
                EXEC: begin
                    acc  <= acc_sh;
                    q    <= q_sh;
                    q_m1 <= q_m1_sh;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        res_h <= acc_sh[63:0];
                        res_l <= q_sh;
                        done  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.result_h = res_h;
    assign bus.result_l = res_l;
    assign bus.op_done  = done;
endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier: random and directed stimulus checked every cycle
// against an arithmetic product model with a fixed-latency done.
module tb_booth_multiplier;
`ifdef BOOTH_RADIX4_EN
    localparam int LAT = 32;
`else
    localparam int LAT = 64;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    booth_multiplier_if ifc ();

    booth_multiplier dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [128:0] act,
                       input logic [128:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural model: product by plain multiplication, done after LAT edges.
    int          phase = 0;
    int          left = 0;
    logic [127:0] pend = '0;
    logic        m_done = 1'b0;
    logic [63:0] m_h = '0;
    logic [63:0] m_l = '0;

    always @(posedge clk) begin
        logic signed [127:0] sa, sb;
        if (reset || ifc.op_clear) begin
            phase = 0; m_done = 1'b0; m_h = '0; m_l = '0;
        end else if (phase == 0) begin
            if (ifc.op_start) begin
                sa = {{64{ifc.multiplier[63]}}, ifc.multiplier};
                sb = {{64{ifc.multiplicand[63]}}, ifc.multiplicand};
                pend = sa * sb;
                left = LAT; phase = 1; m_h = '0; m_l = '0;
            end
        end else if (phase == 1) begin
            left--;
            if (left == 0) begin
                phase = 2; m_done = 1'b1;
                m_h = pend[127:64]; m_l = pend[63:0];
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (!reset)
            chk("cycle", {ifc.op_done, ifc.result_h, ifc.result_l},
                {m_done, m_h, m_l});
    end

    // scr: 0 none, 1 drive 0/0xFF after S0, 2 random operands after S0
    task automatic run(input logic [63:0] a, input logic [63:0] b,
                       input int abort_at, input int scr, output int n);
        @(negedge clk);
        ifc.multiplier = a; ifc.multiplicand = b;
        ifc.op_start = 1'b1; ifc.op_clear = 1'b0;
        n = 0;
        while (n < LAT + 20) begin
            @(posedge clk); #2; n++;
            if (ifc.op_done) break;
            @(negedge clk);
            if (scr == 1) begin
                ifc.multiplier = '0; ifc.multiplicand = 64'hFF;
            end else if (scr == 2) begin
                ifc.multiplier = {$urandom, $urandom};
                ifc.multiplicand = {$urandom, $urandom};
            end
            if (abort_at != 0 && n == abort_at) begin
                ifc.op_clear = 1'b1; ifc.op_start = 1'b0;
                @(negedge clk);
                ifc.op_clear = 1'b0;
                return;
            end
        end
    endtask

    task automatic clear_op();
        @(negedge clk);
        ifc.op_start = 1'b0; ifc.op_clear = 1'b1;
        @(negedge clk);
        ifc.op_clear = 1'b0;
    endtask

    task automatic hold(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #2;
            chk("hold_done", {128'd0, ifc.op_done}, 129'd1);
        end
    endtask

    task automatic directed(input string name, input logic [63:0] a,
                            input logic [63:0] b, input logic [127:0] exp);
        int n;
        run(a, b, 0, 0, n);
        chk({name, "_lat"}, 129'(n), 129'(LAT + 1));
        chk(name, {ifc.op_done, ifc.result_h, ifc.result_l}, {1'b1, exp});
        clear_op();
    endtask

    logic [63:0] corner [6] = '{64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF,
                               64'h8000_0000_0000_0000,
                               64'h7FFF_FFFF_FFFF_FFFF, 64'h5555_5555_5555_5555};

    initial begin
        int n;
        ifc.op_start = 1'b0; ifc.op_clear = 1'b0;
        ifc.multiplier = '0; ifc.multiplicand = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset", {ifc.op_done, ifc.result_h, ifc.result_l}, 129'd0);

        run(64'd5, 64'd4, 0, 0, n);
        chk("5x4_lat", 129'(n), 129'(LAT + 1));
        chk("5x4", {ifc.op_done, ifc.result_h, ifc.result_l},
            {1'b1, 128'h14});
        hold(20);
        chk("5x4_held", {ifc.op_done, ifc.result_h, ifc.result_l},
            {1'b1, 128'h14});
        clear_op();

        directed("m3x7", -64'sd3, 64'd7,
                 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB);
        directed("max_sq", 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                 128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001);
        directed("min_x_m1", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 128'h0000_0000_0000_0000_8000_0000_0000_0000);
        directed("min_sq", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                 128'h4000_0000_0000_0000_0000_0000_0000_0000);

        run(64'd6, 64'd5, 0, 1, n);
        chk("6x5_lat", 129'(n), 129'(LAT + 1));
        chk("6x5_latched", {ifc.op_done, ifc.result_h, ifc.result_l},
            {1'b1, 128'd30});
        clear_op();

        run(64'd9, 64'd9, 10, 0, n);
        chk("abort", {ifc.op_done, ifc.result_h, ifc.result_l}, 129'd0);
        repeat (LAT) @(posedge clk);
        #2;
        chk("abort_idle", {ifc.op_done, ifc.result_h, ifc.result_l}, 129'd0);
        directed("3x3", 64'd3, 64'd3, 128'd9);

        @(negedge clk);
        ifc.op_start = 1'b1; ifc.op_clear = 1'b1;
        ifc.multiplier = 64'd7; ifc.multiplicand = 64'd7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            chk("start_clear", {ifc.op_done, ifc.result_h, ifc.result_l},
                129'd0);
        end
        @(negedge clk);
        ifc.op_start = 1'b0; ifc.op_clear = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #2;
        chk("start_clear_idle", {128'd0, ifc.op_done}, 129'd0);

        run(64'd5, 64'd4, 0, 0, n);
        chk("pre_reset", {ifc.op_done, ifc.result_h, ifc.result_l},
            {1'b1, 128'h14});
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #2;
        chk("reset_done", {ifc.op_done, ifc.result_h, ifc.result_l}, 129'd0);
        @(negedge clk);
        reset = 1'b0; ifc.op_start = 1'b0;

        for (int i = 0; i < 40; i++) begin
            logic [63:0] a, b;
            int ab;
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)]
                                            : {$urandom, $urandom};
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)]
                                            : {$urandom, $urandom};
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, LAT) : 0;
            run(a, b, ab, 2, n);
            if (ab == 0) begin
                chk("rand_lat", 129'(n), 129'(LAT + 1));
                hold($urandom_range(1, 3));
                clear_op();
            end
        end

        repeat (3) @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
